// File: rtl/ifu_fetch_pkg.sv
// Shared widths, reset/NOP constants and FSM encoding for the fetch unit.
package ifu_fetch_pkg;

  localparam int CPU_WIDTH = 32;
  localparam int INS_WIDTH = 32;

  localparam logic [CPU_WIDTH-1:0] RESET_PC_DEFAULT = 32'h8000_0000;
  // addi x0, x0, 0 -- substituted for the payload of a faulting fetch
  localparam logic [INS_WIDTH-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_HOLD = 2'd3
  } fetch_state_e;

  // Sequential successor of a word-aligned pc; wraps modulo 2^32.
  function automatic logic [CPU_WIDTH-1:0] next_seq_pc(input logic [CPU_WIDTH-1:0] pc);
    return pc + CPU_WIDTH'(4);
  endfunction

endpackage

// File: rtl/ifu_fetch_if.sv
// Bundle of the fetch unit's memory, redirect and decoder handshakes.
interface ifu_fetch_if;
  import ifu_fetch_pkg::*;

  logic                 ireq_valid;
  logic                 ireq_ready;
  logic [CPU_WIDTH-1:0] ireq_addr;
  logic                 iresp_valid;
  logic [INS_WIDTH-1:0] iresp_data;
  logic                 iresp_err;
  logic                 redirect;
  logic [CPU_WIDTH-1:0] redirect_pc;
  logic [INS_WIDTH-1:0] instr;
  logic [CPU_WIDTH-1:0] pc;
  logic                 post_valid;
  logic                 post_ready;
  logic                 fetch_err;

  // Fetch unit side
  modport master (
    output ireq_valid, ireq_addr, instr, pc, post_valid, fetch_err,
    input  ireq_ready, iresp_valid, iresp_data, iresp_err,
           redirect, redirect_pc, post_ready
  );

  // Memory / pcu / decoder side
  modport slave (
    input  ireq_valid, ireq_addr, instr, pc, post_valid, fetch_err,
    output ireq_ready, iresp_valid, iresp_data, iresp_err,
           redirect, redirect_pc, post_ready
  );

endinterface

// File: rtl/ifu_fetch.sv
// Single-outstanding instruction fetch unit: request, wait for response,
// hold the instruction for the decoder, with redirect and response drop.
module ifu_fetch
  import ifu_fetch_pkg::*;
#(
  parameter logic [CPU_WIDTH-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  output logic                 o_ireq_valid,
  input  logic                 i_ireq_ready,
  output logic [CPU_WIDTH-1:0] o_ireq_addr,
  input  logic                 i_iresp_valid,
  input  logic [INS_WIDTH-1:0] i_iresp_data,
  input  logic                 i_iresp_err,
  input  logic                 i_redirect,
  input  logic [CPU_WIDTH-1:0] i_redirect_pc,
  output logic [INS_WIDTH-1:0] o_instr,
  output logic [CPU_WIDTH-1:0] o_pc,
  output logic                 o_post_valid,
  input  logic                 i_post_ready,
  output logic                 o_fetch_err
);

  fetch_state_e         state_q, state_d;
  logic [CPU_WIDTH-1:0] pc_q, pc_d;
  logic                 drop_q, drop_d;
  logic [INS_WIDTH-1:0] instr_q, instr_d;
  logic [CPU_WIDTH-1:0] opc_q, opc_d;
  logic                 err_q, err_d;

  // State, pc and captured-instruction registers with async reset
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      drop_q  <= 1'b0;
      instr_q <= '0;
      opc_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      drop_q  <= drop_d;
      instr_q <= instr_d;
      opc_q   <= opc_d;
      err_q   <= err_d;
    end
  end

  // Next-state and datapath update; a redirect always wins over pc+4
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    drop_d  = drop_q;
    instr_d = instr_q;
    opc_d   = opc_q;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ: begin
        if (i_ireq_ready) begin
          state_d = S_WAIT;
          if (i_redirect) begin
            // request already launched for the old pc: its response must go
            pc_d   = i_redirect_pc;
            drop_d = 1'b1;
          end
        end else if (i_redirect) begin
          // not yet accepted, so the address may simply change
          pc_d = i_redirect_pc;
        end
      end
      S_WAIT: begin
        if (i_iresp_valid) begin
          if (drop_q || i_redirect) begin
            state_d = S_REQ;
            drop_d  = 1'b0;
            if (i_redirect) pc_d = i_redirect_pc;
          end else begin
            state_d = S_HOLD;
            instr_d = i_iresp_err ? NOP_INSTR : i_iresp_data;
            opc_d   = pc_q;
            err_d   = i_iresp_err;
          end
        end else if (i_redirect) begin
          pc_d   = i_redirect_pc;
          drop_d = 1'b1;
        end
      end
      S_HOLD: begin
        if (i_post_ready) begin
          state_d = S_REQ;
          pc_d    = i_redirect ? i_redirect_pc : next_seq_pc(pc_q);
        end else if (i_redirect) begin
          // flush the held instruction; valid drops next cycle
          state_d = S_REQ;
          pc_d    = i_redirect_pc;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Handshake outputs decoded purely from state
  always_comb begin
    o_ireq_valid = (state_q == S_REQ);
    o_post_valid = (state_q == S_HOLD);
    o_ireq_addr  = pc_q;
    o_instr      = instr_q;
    o_pc         = opc_q;
    o_fetch_err  = err_q;
  end

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed scenarios for ifu_fetch with a delivery scoreboard.
module tb_ifu_fetch;
  import ifu_fetch_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ifu_fetch_if bus ();

  ifu_fetch #(.RESET_PC(32'h8000_0000)) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .o_ireq_valid  (bus.ireq_valid),
    .i_ireq_ready  (bus.ireq_ready),
    .o_ireq_addr   (bus.ireq_addr),
    .i_iresp_valid (bus.iresp_valid),
    .i_iresp_data  (bus.iresp_data),
    .i_iresp_err   (bus.iresp_err),
    .i_redirect    (bus.redirect),
    .i_redirect_pc (bus.redirect_pc),
    .o_instr       (bus.instr),
    .o_pc          (bus.pc),
    .o_post_valid  (bus.post_valid),
    .i_post_ready  (bus.post_ready),
    .o_fetch_err   (bus.fetch_err)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int n_vectors = 0;
  int n_miscompares = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vectors++;
    if (got !== exp) begin
      n_miscompares++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    return (addr == 32'h8000_0000) ? 32'h0010_0093 : (addr ^ 32'h1357_9BDF);
  endfunction

  // Scoreboard: every decoder handshake must match the oldest expected entry
  always @(negedge clk) begin
    if (rst_n && bus.post_valid && bus.post_ready) begin
      check_val("sb_nonempty", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        $display("deliver pc=%08h instr=%08h err=%0b (exp pc=%08h instr=%08h err=%0b)",
                 bus.pc, bus.instr, bus.fetch_err, e.pc, e.instr, e.err);
        check_val("sb_pc", bus.pc, e.pc);
        check_val("sb_instr", bus.instr, e.instr);
        check_val("sb_err", 32'(bus.fetch_err), 32'(e.err));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req(input logic [31:0] addr);
    int n = 0;
    while (!bus.ireq_valid && n < 20) begin
      tick();
      n++;
    end
    check_val("req_valid", 32'(bus.ireq_valid), 32'd1);
    check_val("req_addr", bus.ireq_addr, addr);
  endtask

  task automatic accept();
    bus.ireq_ready = 1'b1;
    tick();
    bus.ireq_ready = 1'b0;
    check_val("wait_no_req", 32'(bus.ireq_valid), 32'd0);
  endtask

  task automatic respond(input logic [31:0] addr, input logic err, input bit push);
    bus.iresp_valid = 1'b1;
    bus.iresp_data  = mem_word(addr);
    bus.iresp_err   = err;
    if (push) sb.push_back('{addr, err ? NOP_INSTR : mem_word(addr), err});
    tick();
    bus.iresp_valid = 1'b0;
    bus.iresp_err   = 1'b0;
    check_val("post_valid", 32'(bus.post_valid), 32'd1);
  endtask

  task automatic deliver(input int hold, input logic redir, input logic [31:0] target,
                         input logic [31:0] pc, input logic [31:0] instr, input logic err);
    for (int i = 0; i <= hold; i++) begin
      if (i != 0) tick();
      check_val("hold_valid", 32'(bus.post_valid), 32'd1);
      check_val("hold_no_req", 32'(bus.ireq_valid), 32'd0);
      check_val("hold_pc", bus.pc, pc);
      check_val("hold_instr", bus.instr, instr);
      check_val("hold_err", 32'(bus.fetch_err), 32'(err));
    end
    bus.post_ready  = 1'b1;
    bus.redirect    = redir;
    bus.redirect_pc = target;
    tick();
    bus.post_ready = 1'b0;
    bus.redirect   = 1'b0;
    check_val("post_drop", 32'(bus.post_valid), 32'd0);
  endtask

  task automatic fetch(input logic [31:0] addr, input logic err, input int hold);
    wait_req(addr);
    accept();
    respond(addr, err, 1'b1);
    deliver(hold, 1'b0, 32'h0, addr, err ? NOP_INSTR : mem_word(addr), err);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.ireq_ready  = 1'b0;
    bus.iresp_valid = 1'b0;
    bus.iresp_data  = '0;
    bus.iresp_err   = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = '0;
    bus.post_ready  = 1'b0;
    repeat (2) tick();
    check_val("rst_ireq_valid", 32'(bus.ireq_valid), 32'd0);
    check_val("rst_post_valid", 32'(bus.post_valid), 32'd0);
    check_val("rst_instr", bus.instr, 32'h0);
    check_val("rst_pc", bus.pc, 32'h0);
    check_val("rst_err", 32'(bus.fetch_err), 32'd0);

    rst_n = 1'b1;
    check_val("idle_no_req", 32'(bus.ireq_valid), 32'd0);
    tick();
    // basic fetch, then stall in hold, then faulting fetch
    fetch(32'h8000_0000, 1'b0, 0);
    fetch(32'h8000_0004, 1'b0, 5);
    fetch(32'h8000_0008, 1'b1, 0);

    // redirect while waiting: stale response dropped
    wait_req(32'h8000_000C);
    accept();
    bus.redirect = 1'b1; bus.redirect_pc = 32'h8000_0100;
    tick();
    bus.redirect = 1'b0;
    check_val("drop_wait_valid", 32'(bus.post_valid), 32'd0);
    bus.iresp_valid = 1'b1; bus.iresp_data = mem_word(32'h8000_000C);
    tick();
    bus.iresp_valid = 1'b0;
    check_val("dropped_resp", 32'(bus.post_valid), 32'd0);
    fetch(32'h8000_0100, 1'b0, 1);

    // redirect coinciding with the decoder handshake
    wait_req(32'h8000_0104);
    accept();
    respond(32'h8000_0104, 1'b0, 1'b1);
    deliver(0, 1'b1, 32'h8000_0200, 32'h8000_0104, mem_word(32'h8000_0104), 1'b0);
    fetch(32'h8000_0200, 1'b0, 0);

    // redirect while the request is not yet accepted
    wait_req(32'h8000_0204);
    tick();
    check_val("req_addr_stable", bus.ireq_addr, 32'h8000_0204);
    bus.redirect = 1'b1; bus.redirect_pc = 32'h8000_0300;
    tick();
    bus.redirect = 1'b0;
    fetch(32'h8000_0300, 1'b0, 0);

    // redirect in hold without handshake flushes the instruction
    wait_req(32'h8000_0304);
    accept();
    respond(32'h8000_0304, 1'b0, 1'b0);
    bus.redirect = 1'b1; bus.redirect_pc = 32'h8000_0400;
    tick();
    bus.redirect = 1'b0;
    check_val("flush_valid", 32'(bus.post_valid), 32'd0);

    // redirect on the acceptance cycle, then redirect with the response
    wait_req(32'h8000_0400);
    bus.ireq_ready = 1'b1; bus.redirect = 1'b1; bus.redirect_pc = 32'h8000_0500;
    tick();
    bus.ireq_ready = 1'b0; bus.redirect = 1'b0;
    bus.iresp_valid = 1'b1; bus.iresp_data = mem_word(32'h8000_0400);
    tick();
    bus.iresp_valid = 1'b0;
    check_val("drop_accept_valid", 32'(bus.post_valid), 32'd0);
    wait_req(32'h8000_0500);
    accept();
    bus.redirect = 1'b1; bus.redirect_pc = 32'h8000_0600;
    bus.iresp_valid = 1'b1; bus.iresp_data = mem_word(32'h8000_0500);
    tick();
    bus.redirect = 1'b0; bus.iresp_valid = 1'b0;
    check_val("same_cycle_drop", 32'(bus.post_valid), 32'd0);

    // reset while waiting: response during reset never delivered
    wait_req(32'h8000_0600);
    accept();
    rst_n = 1'b0;
    #1;
    check_val("arst_ireq_valid", 32'(bus.ireq_valid), 32'd0);
    check_val("arst_instr", bus.instr, 32'h0);
    check_val("arst_pc", bus.pc, 32'h0);
    bus.iresp_valid = 1'b1; bus.iresp_data = mem_word(32'h8000_0600);
    tick();
    bus.iresp_valid = 1'b0;
    rst_n = 1'b1;
    check_val("arst_post_valid", 32'(bus.post_valid), 32'd0);
    tick();
    // stray response in S_REQ is ignored
    bus.iresp_valid = 1'b1;
    tick();
    bus.iresp_valid = 1'b0;
    check_val("stray_resp", 32'(bus.post_valid), 32'd0);
    fetch(32'h8000_0000, 1'b0, 0);

    // pc wrap at the top of the address space
    wait_req(32'h8000_0004);
    bus.redirect = 1'b1; bus.redirect_pc = 32'hFFFF_FFFC;
    tick();
    bus.redirect = 1'b0;
    fetch(32'hFFFF_FFFC, 1'b0, 0);
    fetch(32'h0000_0000, 1'b0, 0);

    tick();
    check_val("sb_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule

// File: doc/ifu_fetch.md
IFU_FETCH -- requirements
Module: ifu_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h8000_0000: first fetch address after reset.
REQ-002 SHALL have port i_clk  input  1  the single clock; all state on rising edge.
REQ-003 SHALL have port i_rst_n  input  1  reset; asynchronous, active-low.
REQ-004 SHALL have port o_ireq_valid  output  1  instruction-memory request valid.
REQ-005 SHALL have port i_ireq_ready  input  1  memory accepts request.
REQ-006 SHALL have port o_ireq_addr  output  `CPU_WIDTH  request address (word aligned).
REQ-007 SHALL have port i_iresp_valid  input  1  response data valid.
REQ-008 SHALL have port i_iresp_data  input  `INS_WIDTH  fetched instruction.
REQ-009 SHALL have port i_iresp_err  input  1  access fault on response.
REQ-010 SHALL have port i_redirect  input  1  branch/jump taken (from pcu path).
REQ-011 SHALL have port i_redirect_pc  input  `CPU_WIDTH  redirect target.
REQ-012 SHALL have port o_instr  output  `INS_WIDTH  instruction to decoder.
REQ-013 SHALL have port o_pc  output  `CPU_WIDTH  PC of o_instr.
REQ-014 SHALL have port o_post_valid  output  1  o_instr/o_pc valid (drives decoder i_pre_valid).
REQ-015 SHALL have port i_post_ready  input  1  decoder consumes instruction.
REQ-016 SHALL have port o_fetch_err  output  1  held instruction carries access fault.

Function
REQ-017 SHALL implement FSM states S_IDLE, S_REQ, S_WAIT, S_HOLD; o_ireq_valid=1 only in S_REQ; o_post_valid=1 only in S_HOLD.
REQ-018 S_IDLE SHALL go to S_REQ on the first clock edge after reset release.
REQ-019 S_REQ: o_ireq_addr SHALL equal pc and stay stable until i_ireq_ready; on ready go to S_WAIT.
REQ-020 S_WAIT: on i_iresp_valid with no pending drop, capture o_instr=i_iresp_data, o_pc=pc, o_fetch_err=i_iresp_err; go to S_HOLD.
REQ-021 i_iresp_err=1 SHALL force captured o_instr to 32'h0000_0013 (nop) with o_fetch_err=1.
REQ-022 S_HOLD: o_instr/o_pc/o_fetch_err SHALL hold stable until i_post_ready; on handshake pc<=pc+4 (mod 2^32 wrap), go to S_REQ.
REQ-023 Minimum latency: request accepted cycle N, response N+1 -> o_post_valid at N+2; throughput one instruction per 3 cycles.
REQ-024 Redirect in S_REQ with i_ireq_ready=0: pc<=i_redirect_pc, stay S_REQ (address change permitted only here).
REQ-025 Redirect in S_REQ with i_ireq_ready=1, or in S_WAIT: pc<=i_redirect_pc, set drop flag; the next response SHALL be discarded, then go to S_REQ and clear drop.
REQ-026 Redirect in S_WAIT same cycle as i_iresp_valid: response discarded, go to S_REQ directly.
REQ-027 Redirect in S_HOLD without i_post_ready: held instruction flushed, o_post_valid=0 next cycle, pc<=i_redirect_pc, go to S_REQ.
REQ-028 Redirect in S_HOLD with i_post_ready: handshake completes, next pc = i_redirect_pc (not pc+4).
REQ-029 i_iresp_valid outside S_WAIT SHALL be ignored.

Reset
REQ-030 On i_rst_n=0, asynchronously: state=S_IDLE, pc=RESET_PC, drop=0, o_instr=0, o_pc=0, o_fetch_err=0, o_ireq_valid=0, o_post_valid=0.
REQ-031 Reset mid-transaction SHALL abandon any outstanding request; no response is captured afterwards until a new request is issued.

Structure
REQ-032 `CPU_WIDTH, `INS_WIDTH, RESET_PC value, NOP encoding and FSM state encodings SHALL live in the shared defines.vh.
REQ-033 Single module; no sub-module required (pc register and FSM inline).

Verification
REQ-034 Reset release, ready=1, response next cycle with 32'h00100093 -> o_ireq_addr=8000_0000, o_post_valid at cycle 2 after request, o_pc=8000_0000, next request 8000_0004.
REQ-035 i_post_ready=0 for 5 cycles in S_HOLD -> o_instr/o_pc unchanged, no new request issued.
REQ-036 Redirect to 8000_0100 during S_WAIT -> response for old pc dropped, next o_ireq_addr=8000_0100, o_pc=8000_0100 on delivery.
REQ-037 Redirect to 8000_0200 in S_HOLD with i_post_ready=1 -> held instr delivered, next request 8000_0200.
REQ-038 Response with i_iresp_err=1 -> o_instr=0000_0013, o_fetch_err=1, o_post_valid=1.
REQ-039 i_rst_n low in S_WAIT, response arrives during reset -> outputs zero, restart at 8000_0000, stale data never delivered.
